// File: rtl/id_switch_bank.sv
// id_switch_bank: Avalon-MM slave exposing a bank of board switches.
// Switches pass through a two-flop synchroniser, an optional debounce stage,
// sticky change detection with a maskable level interrupt and a change counter.
// Optional feature macro: ID_SWITCH_BANK_DEBOUNCE_EN (per-bit debounce counters).
// Without the macro the debounced register simply follows sync_out one cycle later.

module id_switch_bank #(
  parameter int          WIDTH           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] VERSION         = 32'h5357_0002
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      avalon_slave_address,
  input  logic             avalon_slave_write,
  input  logic [31:0]      avalon_slave_writedata,
  input  logic             avalon_slave_read,
  output logic [31:0]      avalon_slave_readdata,
  output logic             avalon_slave_waitrequest,
  input  logic [WIDTH-1:0] sw,
  output logic             irq
);

  localparam logic [7:0] REG_VERSION = 8'h00;
  localparam logic [7:0] REG_DEB     = 8'h01;
  localparam logic [7:0] REG_RAW     = 8'h02;
  localparam logic [7:0] REG_LATCH   = 8'h03;
  localparam logic [7:0] REG_MASK    = 8'h04;
  localparam logic [7:0] REG_COUNT   = 8'h05;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_next;
  logic [WIDTH-1:0] toggle;
  logic             any_toggle;
  logic [WIDTH-1:0] change_latch;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] latch_clear;
  logic [31:0]      change_count;
  logic             wait_flag;
  logic [31:0]      read_value;
  logic [7:0]       page;
  logic             unused_bits;

  assign page        = avalon_slave_address[15:8];
  assign unused_bits = ^{avalon_slave_address[7:0], avalon_slave_writedata};

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= sw;
      sync_out  <= sync_meta;
    end
  end

`ifdef ID_SWITCH_BANK_DEBOUNCE_EN
  localparam int             CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] deb_cnt;
  logic [WIDTH-1:0][CW-1:0] deb_cnt_next;

  // Per-bit stability counters: accept a new level only after it has held long enough
  always_comb begin
    deb_next     = deb;
    deb_cnt_next = deb_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_out[i] == deb[i]) begin
        deb_cnt_next[i] = '0;
      end else if (deb_cnt[i] == CMAX) begin
        deb_next[i]     = sync_out[i];
        deb_cnt_next[i] = '0;
      end else begin
        deb_cnt_next[i] = deb_cnt[i] + 1'b1;
      end
    end
  end

  // Debounce counter state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) deb_cnt <= '0;
    else       deb_cnt <= deb_cnt_next;
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // No debounce: the accepted value follows the synchroniser output
  always_comb begin
    deb_next = sync_out;
  end
`endif

  assign toggle      = deb_next ^ deb;
  assign any_toggle  = |toggle;
  assign latch_clear = (avalon_slave_write && page == REG_LATCH) ?
                       avalon_slave_writedata[WIDTH-1:0] : '0;

  // Accepted switch value; a set in the latch always beats a simultaneous W1C clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb          <= '0;
      change_latch <= '0;
    end else begin
      deb          <= deb_next;
      change_latch <= (change_latch & ~latch_clear) | toggle;
    end
  end

  // Change-event counter: one count per toggling cycle, any write restarts it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      change_count <= '0;
    end else if (avalon_slave_write && page == REG_COUNT) begin
      change_count <= {31'd0, any_toggle};
    end else begin
      change_count <= change_count + {31'd0, any_toggle};
    end
  end

  // Interrupt mask register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (avalon_slave_write && page == REG_MASK) begin
      irq_mask <= avalon_slave_writedata[WIDTH-1:0];
    end
  end

  // Registered level interrupt from the masked change latch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(change_latch & irq_mask);
  end

  // Read multiplexer over the register map, using pre-write values
  always_comb begin
    read_value = 32'hDEAD_BEEF;
    case (page)
      REG_VERSION: read_value = VERSION;
      REG_DEB:     read_value = zext(deb);
      REG_RAW:     read_value = zext(sync_out);
      REG_LATCH:   read_value = zext(change_latch);
      REG_MASK:    read_value = zext(irq_mask);
      REG_COUNT:   read_value = change_count;
      default:     read_value = 32'hDEAD_BEEF;
    endcase
  end

  // One-cycle read stall: the flag drops for exactly one cycle after a stalled read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_flag <= 1'b1;
    else       wait_flag <= !(avalon_slave_read && wait_flag);
  end

  assign avalon_slave_waitrequest = avalon_slave_read && wait_flag;

  // Read data captured at the edge that ends the stalled cycle, held until the next read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avalon_slave_readdata <= '0;
    end else if (avalon_slave_read && wait_flag) begin
      avalon_slave_readdata <= read_value;
    end
  end

endmodule
